ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single 256x16 synchronous-read RAM between two requesters: port 0 (CPU load/store/fetch path) and port 1 (loader/DMA/debug).
- Sits between the requesters and the RAM, and drives every RAM address, write-enable and write-data pin.
- Policy is round-robin with an optional bounded lock for back-to-back bursts.
- One access per cycle. Read data returns one cycle after grant.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_LOCK, 4, maximum consecutive grants one port may hold under lock (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  when 1, no grants are issued.
- req0, req1  input  1 each  access request, ports 0/1.
- we0, we1  input  1 each  1 = write, 0 = read; valid with req.
- lock0, lock1  input  1 each  request to keep the grant next cycle.
- addr0, addr1  input  ADDR_W each  access address.
- wdata0, wdata1  input  DATA_W each  write data.
- gnt0, gnt1  output  1 each  combinational grant, same cycle as req.
- rvalid0, rvalid1  output  1 each  read data valid for that port.
- rdata  output  DATA_W  shared read data; qualified by rvalid0/1.
- busy  output  1  a grant was issued this cycle (gnt0 | gnt1).
- ram_w_en  output  1  RAM write enable.
- ram_r_addr, ram_w_addr  output  ADDR_W each  RAM read/write addresses.
- ram_w_data  output  DATA_W  RAM write data.
- ram_r_data  input  DATA_W  RAM read data, registered inside the RAM, 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0): prio=0 (port 0 favoured), owner=none, lock_cnt=0, rvalid0=rvalid1=0. While held in reset, gnt0=gnt1=0, busy=0, ram_w_en=0.
- Grant (combinational, evaluated each cycle):
  - hold=1: no grant.
  - Only one port requesting: grant that port.
  - Both requesting and an owner exists with lock_cnt<MAX_LOCK: grant the owner.
  - Otherwise: grant the port selected by prio.
  - At most one gnt is ever high.
- RAM drive:
  - With a grant: ram_r_addr = ram_w_addr = granted addr; ram_w_data = granted wdata; ram_w_en = granted we.
  - With no grant: ram_w_en=0; addresses and data driven from port 0's inputs (don't care).
- Priority update (registered): after any grant, prio points to the non-granted port. With no grant, prio is unchanged.
- Lock state (registered):
  - Granted with lock=1 and already owner: lock_cnt+1.
  - Granted with lock=1 and not owner: owner=port, lock_cnt=1.
  - Granted with lock=0: owner=none, lock_cnt=0.
  - Owner deasserts req: owner cleared next edge.
  - lock_cnt reaching MAX_LOCK while the other port requests: the other port wins the next cycle, and owner/lock_cnt clear.
  - lock_cnt at MAX_LOCK with no competitor: the owner keeps receiving grants. lock_cnt saturates at MAX_LOCK and releases to a competitor on its first request.
- Starvation bound: a continuously requesting port is granted within MAX_LOCK+1 cycles.
- Read return: a granted read (we=0) in cycle N gives rvalid<port>=1 for exactly cycle N+1, with rdata=ram_r_data. Writes produce no rvalid.
- Back-to-back reads: rvalid may toggle between ports on consecutive cycles.
- Simultaneous hazards: write by port X in cycle N and read of the same address by port Y in cycle N+1 returns the new data. Ordering is by grant order only; the RAM handles it.
- Reset mid-read: pending rvalid is dropped, with no spurious rvalid after release.
- hold asserted mid-lock: no grants; owner and lock_cnt are frozen and resume when hold=0.

Decomposition:
- Shared package: ADDR_W and DATA_W defaults, and a port-id enum (PORT_CPU=0, PORT_DMA=1, PORT_NONE).
- Grant logic plus lock counter form a natural sub-module: rr_lock_sel (inputs req/lock/hold; outputs one-hot grant; holds prio/owner/lock_cnt).
- The top level holds the RAM muxing and the rvalid pipeline.

Test Plan:
- Reset, then req0 only, read addr 0x10, RAM[0x10]=0xBEEF → gnt0=1 same cycle; rvalid0=1 next cycle with rdata=0xBEEF; rvalid1 stays 0.
- req0 and req1 continuously, no lock, from reset → grants alternate 0,1,0,1; busy=1 every cycle.
- Port 1 writes 0x1234 to 0x20 in cycle N; port 0 reads 0x20 in N+1 → rvalid0 in N+2 with rdata=0x1234; ram_w_en high only in N.
- Both request, port 0 holds lock0=1, MAX_LOCK=4 → four consecutive gnt0, then gnt1; starvation bound holds.
- hold=1 for 3 cycles with both requesting → no gnt, ram_w_en=0; after release, arbitration resumes at the frozen prio.
- Read granted, then rst_n=0 before the next edge, then release → rvalid0 never asserts; prio=0; the first grant goes to port 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (256 x 16)
//   port_e                  : requester identity, PORT_NONE = no owner
package ram_arbiter_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      PORT_CPU  = 2'd0,
      PORT_DMA  = 2'd1,
      PORT_NONE = 2'd2
   } port_e;
endpackage

// File: rtl/ram_arbiter_rr_lock_sel.sv
// Round-robin grant selector with a bounded lock.
//   clk, rst_n      : clock, async active-low reset
//   hold            : suppress all grants, freeze arbitration state
//   req0/1, lock0/1 : request and keep-grant request per port
//   gnt0/1          : combinational one-hot grant
// State: prio_q (favoured port on a tie), owner_q/cnt_q (current lock holder
// and number of consecutive locked grants, saturating at MAX_LOCK).
module ram_arbiter_rr_lock_sel
   import ram_arbiter_pkg::*;
#(
   parameter int MAX_LOCK = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hold,
   input  logic req0,
   input  logic req1,
   input  logic lock0,
   input  logic lock1,
   output logic gnt0,
   output logic gnt1
);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

   port_e            prio_q, prio_d;
   port_e            owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   port_e            sel;
   port_e            gport;
   logic             glock;

   // Grant: a lone requester always wins; on a tie the lock owner wins until
   // its budget is spent, after which prio decides.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      sel  = prio_q;
      if (owner_q != PORT_NONE && cnt_q < MAX_CNT)
         sel = owner_q;
      if (rst_n && !hold) begin
         if (req0 && !req1)
            gnt0 = 1'b1;
         else if (req1 && !req0)
            gnt1 = 1'b1;
         else if (req0 && req1) begin
            gnt0 = (sel == PORT_CPU);
            gnt1 = (sel == PORT_DMA);
         end
      end
   end

   always_comb begin
      prio_d  = prio_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gport   = gnt0 ? PORT_CPU : PORT_DMA;
      glock   = gnt0 ? lock0 : lock1;
      if (gnt0)
         prio_d = PORT_DMA;
      else if (gnt1)
         prio_d = PORT_CPU;
      // hold freezes the lock state so a burst resumes where it stopped
      if (!hold) begin
         if (gnt0 || gnt1) begin
            if (!glock) begin
               owner_d = PORT_NONE;
               cnt_d   = '0;
            end else if (owner_q == gport) begin
               if (cnt_q != MAX_CNT)
                  cnt_d = cnt_q + 1'b1;
            end else begin
               owner_d = gport;
               cnt_d   = CNT_W'(1);
            end
         end else begin
            // nobody requested, so the owner has dropped its request
            owner_d = PORT_NONE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q  <= PORT_CPU;
         owner_q <= PORT_NONE;
         cnt_q   <= '0;
      end else begin
         prio_q  <= prio_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a 256x16 synchronous-read RAM.
//   clk, rst_n             : clock, async active-low reset
//   hold                   : block all grants
//   req/we/lock/addr/wdata : per-port access request (port 0 CPU, port 1 DMA)
//   gnt0/1, busy           : same-cycle grant, busy = any grant
//   rvalid0/1, rdata       : read return one cycle after a granted read
//   ram_*                  : RAM pins; ram_r_data has 1-cycle latency
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_r_addr,
   output logic [ADDR_W-1:0] ram_w_addr,
   output logic [DATA_W-1:0] ram_w_data,
   input  logic [DATA_W-1:0] ram_r_data
);
   logic rvalid0_q, rvalid0_d;
   logic rvalid1_q, rvalid1_d;

   ram_arbiter_rr_lock_sel #(.MAX_LOCK(MAX_LOCK)) u_sel (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (hold),
      .req0  (req0),
      .req1  (req1),
      .lock0 (lock0),
      .lock1 (lock1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   // Port 0 is the default mux leg, so with no grant the RAM sees port 0's
   // inputs with the write enable forced low.
   always_comb begin
      busy       = gnt0 | gnt1;
      ram_r_addr = gnt1 ? addr1 : addr0;
      ram_w_addr = ram_r_addr;
      ram_w_data = gnt1 ? wdata1 : wdata0;
      ram_w_en   = (gnt0 & we0) | (gnt1 & we1);
      rvalid0_d  = gnt0 & ~we0;
      rvalid1_d  = gnt1 & ~we1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata   = ram_r_data;
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        hold, req0, req1, we0, we1, lock0, lock1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_w_en;
   logic [15:0] rdata, ram_w_data, ram_r_data;
   logic [7:0]  ram_r_addr, ram_w_addr;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy),
      .ram_w_en(ram_w_en), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
      .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
   );

   // RAM model: mem[i] = 16'hA500 | i, except mem[0x10] = 16'hBEEF
   logic [15:0] mem [256];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
         mem[8'h10] <= 16'hBEEF;
         loaded     <= 1'b1;
      end else begin
         if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
         ram_r_data <= mem[ram_r_addr];
      end
   end

   typedef struct {
      logic hold, req0, req1, we0, we1, lock0, lock1;
      logic [7:0]  addr0, addr1;
      logic [15:0] wd0, wd1;
      logic        g0, g1, wen;
      logic [7:0]  eaddr;
      logic [15:0] ewd;
      logic        rv0, rv1;
      logic [15:0] erd;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      hold = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   task automatic apply_reset();
      clear_in();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // fields: hold,req0,req1,we0,we1,lock0,lock1,addr0,addr1,wd0,wd1,
      //         g0,g1,wen,eaddr,ewd,rv0,rv1,erd
      tbl[0]  = '{0,1,1,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    1,0,0,8'h01,16'h0,    0,0,16'h0};
      tbl[1]  = '{0,1,1,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    0,1,0,8'h02,16'h0,    1,0,16'hA501};
      tbl[2]  = '{0,1,1,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    1,0,0,8'h01,16'h0,    0,1,16'hA502};
      tbl[3]  = '{0,1,1,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    0,1,0,8'h02,16'h0,    1,0,16'hA501};
      tbl[4]  = '{0,1,0,0,0,0,0,8'h10,8'h02,16'h0,16'h0,    1,0,0,8'h10,16'h0,    0,1,16'hA502};
      tbl[5]  = '{0,0,0,0,0,0,0,8'h10,8'h02,16'h0,16'h0,    0,0,0,8'h10,16'h0,    1,0,16'hBEEF};
      tbl[6]  = '{0,0,1,0,1,0,0,8'h00,8'h20,16'h0,16'h1234, 0,1,1,8'h20,16'h1234, 0,0,16'h0};
      tbl[7]  = '{0,1,0,0,0,0,0,8'h20,8'h00,16'h0,16'h0,    1,0,0,8'h20,16'h0,    0,0,16'h0};
      tbl[8]  = '{0,0,0,0,0,0,0,8'h20,8'h00,16'h0,16'h0,    0,0,0,8'h20,16'h0,    1,0,16'h1234};
      tbl[9]  = '{1,1,1,0,1,0,0,8'h05,8'h06,16'h0,16'hFFFF, 0,0,0,8'h05,16'h0,    0,0,16'h0};
      tbl[10] = '{1,1,1,0,1,0,0,8'h05,8'h06,16'h0,16'hFFFF, 0,0,0,8'h05,16'h0,    0,0,16'h0};
      tbl[11] = '{1,1,1,0,1,0,0,8'h05,8'h06,16'h0,16'hFFFF, 0,0,0,8'h05,16'h0,    0,0,16'h0};
      tbl[12] = '{0,1,1,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    0,1,0,8'h02,16'h0,    0,0,16'h0};
      tbl[13] = '{0,0,0,0,0,0,0,8'h01,8'h02,16'h0,16'h0,    0,0,0,8'h01,16'h0,    0,1,16'hA502};

      // reset state, with requests present to show they are gated
      clear_in();
      rst_n = 0; req0 = 1; req1 = 1; we0 = 1;
      @(negedge clk);
      check("rst gnt0", gnt0, 0);
      check("rst gnt1", gnt1, 0);
      check("rst busy", busy, 0);
      check("rst ram_w_en", ram_w_en, 0);
      check("rst rvalid0", rvalid0, 0);
      check("rst rvalid1", rvalid1, 0);
      apply_reset();

      // directed vector table, one vector per cycle starting just after reset
      for (int i = 0; i < 14; i++) begin
         hold = tbl[i].hold; req0 = tbl[i].req0; req1 = tbl[i].req1;
         we0 = tbl[i].we0; we1 = tbl[i].we1; lock0 = tbl[i].lock0; lock1 = tbl[i].lock1;
         addr0 = tbl[i].addr0; addr1 = tbl[i].addr1;
         wdata0 = tbl[i].wd0; wdata1 = tbl[i].wd1;
         @(negedge clk);
         check($sformatf("v%0d gnt0", i), gnt0, tbl[i].g0);
         check($sformatf("v%0d gnt1", i), gnt1, tbl[i].g1);
         check($sformatf("v%0d busy", i), busy, tbl[i].g0 | tbl[i].g1);
         check($sformatf("v%0d ram_w_en", i), ram_w_en, tbl[i].wen);
         check($sformatf("v%0d ram_r_addr", i), ram_r_addr, tbl[i].eaddr);
         check($sformatf("v%0d ram_w_addr", i), ram_w_addr, tbl[i].eaddr);
         if (tbl[i].wen) check($sformatf("v%0d ram_w_data", i), ram_w_data, tbl[i].ewd);
         check($sformatf("v%0d rvalid0", i), rvalid0, tbl[i].rv0);
         check($sformatf("v%0d rvalid1", i), rvalid1, tbl[i].rv1);
         if (tbl[i].rv0 | tbl[i].rv1) check($sformatf("v%0d rdata", i), rdata, tbl[i].erd);
         tick();
      end

      // lock burst: four grants to port 0, then port 1 within MAX_LOCK+1
      apply_reset();
      req0 = 1; req1 = 1; lock0 = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("lock c%0d gnt0", k), gnt0, (k < 4));
         check($sformatf("lock c%0d gnt1", k), gnt1, (k == 4));
         tick();
      end

      // saturation: lone locked owner keeps grants, yields on first competitor
      apply_reset();
      req0 = 1; lock0 = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("sat c%0d gnt0", k), gnt0, 1);
         tick();
      end
      req1 = 1;
      @(negedge clk);
      check("sat yield gnt1", gnt1, 1);
      check("sat yield gnt0", gnt0, 0);
      tick();
      @(negedge clk);
      check("sat after gnt0", gnt0, 1);
      tick();

      // hold mid-lock freezes owner/count; burst resumes with 2 more grants
      apply_reset();
      req0 = 1; req1 = 1; lock0 = 1;
      for (int k = 0; k < 7; k++) begin
         hold = (k == 2 || k == 3);
         @(negedge clk);
         check($sformatf("hold c%0d gnt0", k), gnt0, (k < 2 || k == 4 || k == 5));
         check($sformatf("hold c%0d gnt1", k), gnt1, (k == 6));
         if (hold) check($sformatf("hold c%0d busy", k), busy, 0);
         tick();
      end
      hold = 0;

      // reset mid-read: pending rvalid dropped, port 0 favoured afterwards
      apply_reset();
      req0 = 1; addr0 = 8'h10;
      @(negedge clk);
      check("rmr gnt0", gnt0, 1);
      #1 rst_n = 0;
      #1;
      check("rmr gnt0 in reset", gnt0, 0);
      check("rmr busy in reset", busy, 0);
      tick();
      check("rmr rvalid0 in reset", rvalid0, 0);
      rst_n = 1; req0 = 0;
      @(negedge clk);
      check("rmr rvalid0 after", rvalid0, 0);
      check("rmr rvalid1 after", rvalid1, 0);
      tick();
      check("rmr rvalid0 later", rvalid0, 0);
      req0 = 1; req1 = 1;
      @(negedge clk);
      check("rmr first gnt0", gnt0, 1);
      check("rmr first gnt1", gnt1, 0);
      tick();
      clear_in();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
